// File: rtl/spi_slave_if_if.sv
// Bus bundle between the SPI serial front-end and its master/memory side.
// The slave modport is the front-end's view; the master modport is the other side.
interface spi_slave_if_if #(
    parameter int ADDR_SIZE = 8
);
    logic                 SS_n;
    logic                 MOSI;
    logic                 MISO;
    logic [ADDR_SIZE+1:0] rx_data;
    logic                 rx_valid;
    logic [ADDR_SIZE-1:0] tx_data;
    logic                 tx_valid;

    modport slave (
        input  SS_n,
        input  MOSI,
        input  tx_data,
        input  tx_valid,
        output MISO,
        output rx_data,
        output rx_valid
    );

    modport master (
        output SS_n,
        output MOSI,
        output tx_data,
        output tx_valid,
        input  MISO,
        input  rx_data,
        input  rx_valid
    );
endinterface

// File: rtl/spi_slave_if.sv
// SPI slave front-end: collects (ADDR_SIZE+2)-bit command words from MOSI and
// shifts the memory's read-data response out on MISO, MSB first.
module spi_slave_if #(
    parameter int MEM_DEPTH = 256
) (
    input  logic           clk,
    input  logic           rst_n,
    spi_slave_if_if.slave  bus
);
    localparam int ADDR_SIZE = $clog2(MEM_DEPTH);
    localparam int FRAME     = ADDR_SIZE + 2;
    localparam int CNT_W     = $clog2(ADDR_SIZE + 3);
    localparam int TXC_W     = $clog2(ADDR_SIZE + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     bit_cnt_reg, bit_cnt_next;
    logic [FRAME-2:0]     shift_reg, shift_next;
    logic [FRAME-1:0]     rx_data_reg, rx_data_next;
    logic                 rx_valid_reg, rx_valid_next;
    logic                 miso_reg, miso_next;
    logic                 rd_addr_received_reg, rd_addr_received_next;
    logic [ADDR_SIZE-1:0] tx_shift_reg, tx_shift_next;
    logic [TXC_W-1:0]     tx_cnt_reg, tx_cnt_next;
    logic                 tx_busy_reg, tx_busy_next;
    logic                 tx_done_reg, tx_done_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg            <= IDLE;
            bit_cnt_reg          <= '0;
            shift_reg            <= '0;
            rx_data_reg          <= '0;
            rx_valid_reg         <= 1'b0;
            miso_reg             <= 1'b0;
            rd_addr_received_reg <= 1'b0;
            tx_shift_reg         <= '0;
            tx_cnt_reg           <= '0;
            tx_busy_reg          <= 1'b0;
            tx_done_reg          <= 1'b0;
        end else begin
            state_reg            <= state_next;
            bit_cnt_reg          <= bit_cnt_next;
            shift_reg            <= shift_next;
            rx_data_reg          <= rx_data_next;
            rx_valid_reg         <= rx_valid_next;
            miso_reg             <= miso_next;
            rd_addr_received_reg <= rd_addr_received_next;
            tx_shift_reg         <= tx_shift_next;
            tx_cnt_reg           <= tx_cnt_next;
            tx_busy_reg          <= tx_busy_next;
            tx_done_reg          <= tx_done_next;
        end
    end

    always_comb begin
        state_next            = state_reg;
        bit_cnt_next          = bit_cnt_reg;
        shift_next            = shift_reg;
        rx_data_next          = rx_data_reg;
        rx_valid_next         = 1'b0;
        miso_next             = miso_reg;
        rd_addr_received_next = rd_addr_received_reg;
        tx_shift_next         = tx_shift_reg;
        tx_cnt_next           = tx_cnt_reg;
        tx_busy_next          = tx_busy_reg;
        tx_done_next          = tx_done_reg;

        if (bus.SS_n) begin
            // Frame end/abort: partial data dropped, read-address memory kept.
            state_next   = IDLE;
            bit_cnt_next = '0;
            shift_next   = '0;
            miso_next    = 1'b0;
            tx_busy_next = 1'b0;
            tx_done_next = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next   = CHK_CMD;
                    bit_cnt_next = '0;
                end
                CHK_CMD: begin
                    if (!bus.MOSI)
                        state_next = WRITE;
                    else if (rd_addr_received_reg)
                        state_next = READ_DATA;
                    else
                        state_next = READ_ADD;
                end
                WRITE, READ_ADD, READ_DATA: begin
                    // Counter stops at FRAME, so trailing bits are ignored.
                    if (bit_cnt_reg < CNT_W'(FRAME)) begin
                        shift_next   = {shift_reg[FRAME-3:0], bus.MOSI};
                        bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                        if (bit_cnt_reg == CNT_W'(FRAME - 1)) begin
                            rx_data_next  = {shift_reg, bus.MOSI};
                            rx_valid_next = 1'b1;
                            if (state_reg == READ_ADD)
                                rd_addr_received_next = 1'b1;
                        end
                    end
                    if (state_reg == READ_DATA) begin
                        if (tx_busy_reg) begin
                            if (tx_cnt_reg != '0) begin
                                miso_next     = tx_shift_reg[ADDR_SIZE-1];
                                tx_shift_next = {tx_shift_reg[ADDR_SIZE-2:0], 1'b0};
                                tx_cnt_next   = tx_cnt_reg - TXC_W'(1);
                            end else begin
                                miso_next             = 1'b0;
                                tx_busy_next          = 1'b0;
                                tx_done_next          = 1'b1;
                                rd_addr_received_next = 1'b0;
                            end
                        end else if (!tx_done_reg && bus.tx_valid &&
                                     bit_cnt_reg == CNT_W'(FRAME)) begin
                            // MSB goes out straight away; the rest follow from tx_shift.
                            miso_next     = bus.tx_data[ADDR_SIZE-1];
                            tx_shift_next = {bus.tx_data[ADDR_SIZE-2:0], 1'b0};
                            tx_cnt_next   = TXC_W'(ADDR_SIZE - 1);
                            tx_busy_next  = 1'b1;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign bus.MISO     = miso_reg;
    assign bus.rx_data  = rx_data_reg;
    assign bus.rx_valid = rx_valid_reg;

    a_rx_valid_single: assert property (@(posedge clk) disable iff (!rst_n)
        rx_valid_reg |=> !rx_valid_reg);
    a_rx_valid_state: assert property (@(posedge clk) disable iff (!rst_n)
        rx_valid_reg |-> (state_reg inside {WRITE, READ_ADD, READ_DATA}));
    a_miso_idle: assert property (@(posedge clk) disable iff (!rst_n)
        (state_reg == IDLE) |-> !miso_reg);
endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: write/read frames, abort, and async reset
// during MISO serialisation.
module tb_spi_slave_if;
    localparam logic [2:0] S_IDLE = 3'd0, S_CHK = 3'd1, S_WRITE = 3'd2,
                           S_RADD = 3'd3, S_RDATA = 3'd4;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    spi_slave_if_if #(.ADDR_SIZE(8)) bus ();

    spi_slave_if #(.MEM_DEPTH(256)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    logic [2:0] state_probe;
    logic       rd_probe;
    assign state_probe = dut.state_reg;
    assign rd_probe    = dut.rd_addr_received_reg;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one full frame up to one cycle past the rx_valid strobe.
    task automatic frame(input string tag, input logic rw, input logic [9:0] w,
                         input logic [2:0] st);
        bus.SS_n = 1'b0;
        tick();
        chk({tag, ":state_chk"}, 32'(state_probe), 32'(S_CHK));
        bus.MOSI = rw;
        tick();
        chk({tag, ":state"}, 32'(state_probe), 32'(st));
        for (int i = 9; i >= 0; i--) begin
            bus.MOSI = w[i];
            tick();
            if (i > 0) chk({tag, ":early_valid"}, 32'(bus.rx_valid), 32'd0);
        end
        chk({tag, ":rx_valid"}, 32'(bus.rx_valid), 32'd1);
        chk({tag, ":rx_data"}, 32'(bus.rx_data), 32'(w));
        chk({tag, ":miso"}, 32'(bus.MISO), 32'd0);
        bus.MOSI = 1'b1;
        tick();
        chk({tag, ":pulse_end"}, 32'(bus.rx_valid), 32'd0);
        $display("frame %s rw=%0b word=%03h rx_data=%03h", tag, rw, w, bus.rx_data);
    endtask

    task automatic end_frame(input string tag);
        bus.SS_n = 1'b1;
        tick();
        chk({tag, ":idle"}, 32'(state_probe), 32'(S_IDLE));
        chk({tag, ":idle_miso"}, 32'(bus.MISO), 32'd0);
    endtask

    initial begin
        logic [7:0] txv;
        rst_n        = 1'b0;
        bus.SS_n     = 1'b1;
        bus.MOSI     = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        #12;
        chk("rst:miso", 32'(bus.MISO), 32'd0);
        chk("rst:rx_data", 32'(bus.rx_data), 32'd0);
        chk("rst:rx_valid", 32'(bus.rx_valid), 32'd0);
        chk("rst:state", 32'(state_probe), 32'(S_IDLE));
        chk("rst:rd_addr", 32'(rd_probe), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Write-address frame, then extra bits that must be ignored
        frame("wr_addr", 1'b0, 10'h02A, S_WRITE);
        for (int k = 0; k < 3; k++) begin
            bus.MOSI = k[0];
            tick();
            chk("wr_addr:no_second", 32'(bus.rx_valid), 32'd0);
            chk("wr_addr:still_write", 32'(state_probe), 32'(S_WRITE));
        end
        end_frame("wr_addr");

        // Write-data frame
        frame("wr_data", 1'b0, 10'h1C3, S_WRITE);
        end_frame("wr_data");

        // tx_valid outside READ_DATA must not disturb MISO
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hFF;
        tick();
        chk("tx_idle:miso", 32'(bus.MISO), 32'd0);
        bus.tx_valid = 1'b0;

        // Read-address frame
        frame("rd_addr", 1'b1, 10'h22A, S_RADD);
        chk("rd_addr:flag", 32'(rd_probe), 32'd1);
        end_frame("rd_addr");
        chk("rd_addr:flag_kept", 32'(rd_probe), 32'd1);

        // Read-data frame with A5 response
        frame("rd_data", 1'b1, 10'h300, S_RDATA);
        txv = 8'hA5;
        bus.tx_valid = 1'b1;
        bus.tx_data  = txv;
        for (int i = 7; i >= 0; i--) begin
            tick();
            bus.tx_valid = 1'b0;
            bus.tx_data  = 8'h00;
            chk("rd_data:miso_bit", 32'(bus.MISO), 32'(txv[i]));
            $display("miso bit %0d = %0b", i, bus.MISO);
        end
        tick();
        chk("rd_data:miso_after", 32'(bus.MISO), 32'd0);
        chk("rd_data:flag_clr", 32'(rd_probe), 32'd0);
        tick();
        chk("rd_data:miso_stays", 32'(bus.MISO), 32'd0);
        end_frame("rd_data");

        // Abort a write frame after 5 payload bits
        bus.SS_n = 1'b0;
        tick();
        bus.MOSI = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            bus.MOSI = 1'b1;
            tick();
        end
        bus.SS_n = 1'b1;
        tick();
        chk("abort:state", 32'(state_probe), 32'(S_IDLE));
        chk("abort:rx_valid", 32'(bus.rx_valid), 32'd0);
        tick();
        chk("abort:rx_valid2", 32'(bus.rx_valid), 32'd0);
        chk("abort:rx_data_kept", 32'(bus.rx_data), 32'h300);
        frame("after_abort", 1'b0, 10'h155, S_WRITE);
        end_frame("after_abort");

        // Read serialisation aborted by SS_n: flag must survive
        frame("rd_addr2", 1'b1, 10'h2AA, S_RADD);
        end_frame("rd_addr2");
        frame("rd_abort", 1'b1, 10'h300, S_RDATA);
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hFF;
        tick();
        bus.tx_valid = 1'b0;
        chk("rd_abort:miso", 32'(bus.MISO), 32'd1);
        tick();
        bus.SS_n = 1'b1;
        tick();
        chk("rd_abort:miso0", 32'(bus.MISO), 32'd0);
        chk("rd_abort:flag_kept", 32'(rd_probe), 32'd1);
        chk("rd_abort:state", 32'(state_probe), 32'(S_IDLE));

        // Async reset in the middle of MISO serialisation
        frame("rd_rst", 1'b1, 10'h3FF, S_RDATA);
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h3C;
        tick();
        bus.tx_valid = 1'b0;
        tick();
        tick();
        chk("rd_rst:miso_bit5", 32'(bus.MISO), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst:miso", 32'(bus.MISO), 32'd0);
        chk("async_rst:rx_valid", 32'(bus.rx_valid), 32'd0);
        chk("async_rst:rx_data", 32'(bus.rx_data), 32'd0);
        chk("async_rst:state", 32'(state_probe), 32'(S_IDLE));
        chk("async_rst:rd_addr", 32'(rd_probe), 32'd0);
        $display("async reset mid-serialisation applied");
        bus.SS_n = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst:state", 32'(state_probe), 32'(S_IDLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
- Serial front-end of the SPI wrapper.
- Deserialises MOSI frames into (ADDR_SIZE+2)-bit command words for the downstream memory stage (rx_data/rx_valid).
- Serialises the memory's read-data response (tx_data/tx_valid) back onto MISO.
- Runs a 5-state FSM clocked by the SPI clock; tracks whether a read address has been sent, so a read-command frame becomes either an address phase or a data phase.

Parameters:
- MEM_DEPTH, 256, depth of the downstream memory.
- ADDR_SIZE, $clog2(MEM_DEPTH) (=8), address/data width (localparam).

Ports:
- clk  in  1  SPI clock; all logic on posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- SS_n  in  1  slave select, active-low; frame boundary.
- MOSI  in  1  serial data in, MSB first.
- MISO  out  1  serial data out, MSB first.
- rx_data  out  ADDR_SIZE+2  parallel command word {cmd[1:0], payload[ADDR_SIZE-1:0]}.
- rx_valid  out  1  one-cycle strobe, rx_data valid.
- tx_data  in  ADDR_SIZE  read data from memory.
- tx_valid  in  1  tx_data valid strobe.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; MISO=0, rx_data=0, rx_valid=0.
  - bit counter=0; shift reg=0; rd_addr_received=0.
  - Reset mid-frame aborts the frame with no rx_valid.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: SS_n=0 -> CHK_CMD; else stay.
- CHK_CMD: samples MOSI (R/W bit).
  - MOSI=0 -> WRITE.
  - MOSI=1 and rd_addr_received=0 -> READ_ADD.
  - MOSI=1 and rd_addr_received=1 -> READ_DATA.
- SS_n=1 in any state -> IDLE next cycle:
  - counter cleared; rx_valid=0; MISO=0.
  - partial shift data discarded; rd_addr_received unchanged.
- WRITE / READ_ADD / READ_DATA, collection phase:
  - Each cycle shifts MOSI in, MSB first, counting ADDR_SIZE+2 bits.
  - On the cycle the last bit is sampled: rx_data <= {shift[ADDR_SIZE:0], MOSI}; rx_valid=1 for exactly one cycle (visible the cycle after the last bit).
  - Further MOSI bits in the same frame are ignored; no second rx_valid per frame.
- READ_ADD: rd_addr_received set to 1 with the rx_valid strobe.
- READ_DATA:
  - After the rx_valid strobe, waits for tx_valid=1.
  - On tx_valid, latches tx_data.
  - Starting the next cycle, drives MISO with tx_data[ADDR_SIZE-1] down to bit 0, one bit per cycle (ADDR_SIZE cycles).
  - Then MISO=0; rd_addr_received cleared to 0 after the last bit.
  - tx_valid before the rx_valid strobe, or outside READ_DATA, is ignored.
  - SS_n=1 before serialisation completes: MISO=0, rd_addr_received stays 1.
- MISO=0 whenever not serialising.
- Payload bits are passed through unmodified; cmd bits are not checked. Consistency with the R/W bit is the master's responsibility.
- Counter width ≥ $clog2(ADDR_SIZE+3); no wrap within a frame (saturates after the final bit).
- Assertions (sim-only):
  - rx_valid never high two consecutive cycles.
  - rx_valid implies state ∈ {WRITE, READ_ADD, READ_DATA}.
  - MISO=0 in IDLE.

Test Plan:
- Write-address frame: SS_n=0, MOSI=0 then 10'b00_0010_1010 -> rx_data=10'h02A, single rx_valid pulse, state=WRITE until SS_n=1, then IDLE.
- Write-data frame: MOSI=0 then 10'b01_1100_0011 -> rx_data=10'h1C3, rx_valid one cycle, MISO stays 0 throughout.
- Read-address frame: MOSI=1 then 10'b10_0010_1010 with rd_addr_received=0 -> state READ_ADD, rx_data=10'h22A, rd_addr_received=1 after the strobe.
- Read-data frame: MOSI=1 then 10'b11_0000_0000 -> state READ_DATA, rx_data=10'h300; bench returns tx_valid=1, tx_data=8'hA5 -> MISO=1,0,1,0,0,1,0,1 on the next 8 cycles; rd_addr_received=0 afterwards.
- Abort: SS_n rises after 5 data bits of a write frame -> no rx_valid, IDLE next cycle; next full frame decodes correctly.
- Async reset asserted during MISO serialisation -> MISO, rx_valid, rx_data=0 immediately, state=IDLE, rd_addr_received=0.
